// File: rtl/onehot_dec_seq.sv
// Sequenced 2-to-4 one-hot decoder with hold/gap windowing and line history.
// Ports: clk, rst (async high), in_valid/in_ready/in_idx/in_en request
// handshake, clr (sync hist clear), y (one-hot), busy, done, hist (sticky).
module onehot_dec_seq #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_idx,
  input  logic       in_en,
  input  logic       clr,
  output logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic [3:0] hist
);

  if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
    $error("onehot_dec_seq: HOLD must be 1..15");
  end
  if (GAP > 15) begin : g_bad_gap
    $error("onehot_dec_seq: GAP must be 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_M1  = 4'(HOLD - 1);
  // Only used when GAP>0, so the wrap for GAP==0 is harmless.
  localparam logic [3:0] GAP_M1   = 4'(GAP - 1);
  localparam logic       ONE_HOLD = (HOLD == 1);
  localparam logic       HAS_GAP  = (GAP > 0);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_y;
  logic [3:0] r_hist;
  logic       r_busy;
  logic       r_ready;
  logic       r_done;

  logic       w_accept;
  logic [3:0] w_line;
  logic [3:0] w_newbit;

  assign w_accept = in_valid & r_ready;
  assign w_line   = 4'b0001 << in_idx;
  assign w_newbit = (w_accept & in_en) ? w_line : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_y     <= 4'b0000;
      r_hist  <= 4'b0000;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      // A clear coinciding with an accept keeps only the new line.
      r_hist <= (clr ? 4'b0000 : r_hist) | w_newbit;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_HOLD;
            r_cnt   <= HOLD_M1;
            r_y     <= in_en ? w_line : 4'b0000;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_done  <= ONE_HOLD;
          end
        end
        S_HOLD: begin
          if (r_cnt != 4'd0) begin
            r_cnt  <= r_cnt - 4'd1;
            // Pulse lands on the cycle whose count reaches zero.
            r_done <= (r_cnt == 4'd1);
          end else begin
            r_y    <= 4'b0000;
            r_done <= 1'b0;
            if (HAS_GAP) begin
              r_state <= S_GAP;
              r_cnt   <= GAP_M1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
          r_y     <= 4'b0000;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_ready;
  assign y        = r_y;
  assign busy     = r_busy;
  assign done     = r_done;
  assign hist     = r_hist;

endmodule

// File: tb/tb_onehot_dec_seq.sv
// Self-checking bench for onehot_dec_seq: default and HOLD=1/GAP=0 instances
// compared cycle by cycle against a time-since-accept reference model.
module tb_onehot_dec_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       a_valid = 1'b0, a_en = 1'b0, a_clr = 1'b0;
  logic [1:0] a_idx = 2'd0;
  logic       a_ready, a_busy, a_done;
  logic [3:0] a_y, a_hist;

  logic       b_valid = 1'b0, b_en = 1'b0, b_clr = 1'b0;
  logic [1:0] b_idx = 2'd0;
  logic       b_ready, b_busy, b_done;
  logic [3:0] b_y, b_hist;

  onehot_dec_seq #(.HOLD(4), .GAP(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_valid), .in_ready(a_ready),
    .in_idx(a_idx), .in_en(a_en), .clr(a_clr),
    .y(a_y), .busy(a_busy), .done(a_done), .hist(a_hist)
  );

  onehot_dec_seq #(.HOLD(1), .GAP(0)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_valid), .in_ready(b_ready),
    .in_idx(b_idx), .in_en(b_en), .clr(b_clr),
    .y(b_y), .busy(b_busy), .done(b_done), .hist(b_hist)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: t = cycles since accept (0 = idle).
  int         ma_t = 0, ma_idx = 0;
  bit         ma_en = 0;
  logic [3:0] ma_h = 4'b0;
  int         mb_t = 0, mb_idx = 0;
  bit         mb_en = 0;
  logic [3:0] mb_h = 4'b0;

  // {y, busy, done, ready, hist}
  function automatic logic [10:0] expv(int t, int idx, bit en,
                                       logic [3:0] h, int H);
    logic [3:0] yy;
    yy = (t >= 1 && t <= H && en) ? 4'(1 << idx) : 4'b0000;
    return {yy, t != 0, t == H, t == 0, h};
  endfunction

  task automatic adv(inout int t, inout int idx, inout bit en,
                     inout logic [3:0] h, input bit v, input int i,
                     input bit e, input bit c, input int H, input int G);
    bit acc;
    acc = v && (t == 0);
    h = (c ? 4'b0000 : h) | ((acc && e) ? 4'(1 << i) : 4'b0000);
    if (acc) begin
      t = 1; idx = i; en = e;
    end else if (t != 0) begin
      t = (t == H + G) ? 0 : t + 1;
    end
  endtask

  task automatic mdl_reset();
    ma_t = 0; ma_h = 4'b0;
    mb_t = 0; mb_h = 4'b0;
  endtask

  task automatic step(input bit va, input int ia, input bit ea, input bit ca,
                      input bit vb, input int ib, input bit eb, input bit cb);
    a_valid = va; a_idx = 2'(ia); a_en = ea; a_clr = ca;
    b_valid = vb; b_idx = 2'(ib); b_en = eb; b_clr = cb;
    adv(ma_t, ma_idx, ma_en, ma_h, va, ia, ea, ca, 4, 1);
    adv(mb_t, mb_idx, mb_en, mb_h, vb, ib, eb, cb, 1, 0);
    @(negedge clk);
  endtask

  function automatic logic [10:0] got_a();
    return {a_y, a_busy, a_done, a_ready, a_hist};
  endfunction

  function automatic logic [10:0] got_b();
    return {b_y, b_busy, b_done, b_ready, b_hist};
  endfunction

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({a_y, a_busy, a_ready, a_hist, b_y, b_busy, b_ready, b_hist}
        !== {4'b0, 1'b0, 1'b1, 4'b0, 4'b0, 1'b0, 1'b1, 4'b0}) begin
      n_err++;
      $display("FAIL reset_now got a=%b b=%b exp y0 busy0 ready1 hist0",
               got_a(), got_b());
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if ({got_a(), got_b()} !== {expv(ma_t, ma_idx, ma_en, ma_h, 4),
                                expv(mb_t, mb_idx, mb_en, mb_h, 1)}) begin
      n_err++;
      $display("FAIL reset_release got a=%b b=%b", got_a(), got_b());
    end
  endtask

  task automatic test_single();
    for (int c = 0; c < 8; c++) begin
      step(c == 0, 2, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (got_a() !== expv(ma_t, ma_idx, ma_en, ma_h, 4)) begin
        n_err++;
        $display("FAIL single c=%0d got=%b exp=%b", c + 1, got_a(),
                 expv(ma_t, ma_idx, ma_en, ma_h, 4));
      end
    end
    n_vec++;
    if (a_hist !== 4'b0100) begin
      n_err++;
      $display("FAIL single_hist got=%b exp=0100", a_hist);
    end
  endtask

  task automatic test_back_to_back();
    int seq[3] = '{0, 1, 3};
    int k = 0;
    int dc[$];
    bit acc;
    for (int c = 0; c < 20; c++) begin
      acc = (ma_t == 0) && (k < 3);
      step(k < 3, seq[(k < 3) ? k : 2], 1, c == 0, 0, 0, 0, 0);
      if (acc) k++;
      if (a_done) dc.push_back(c);
      n_vec++;
      if (got_a() !== expv(ma_t, ma_idx, ma_en, ma_h, 4)) begin
        n_err++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, got_a(),
                 expv(ma_t, ma_idx, ma_en, ma_h, 4));
      end
    end
    n_vec++;
    if (dc.size() != 3 || dc[1] - dc[0] != 6 || dc[2] - dc[1] != 6) begin
      n_err++;
      $display("FAIL b2b_spacing got %0d pulses exp 3 pulses 6 apart",
               dc.size());
    end
    n_vec++;
    if (a_hist !== 4'b1011) begin
      n_err++;
      $display("FAIL b2b_hist got=%b exp=1011", a_hist);
    end
  endtask

  task automatic test_disabled();
    int nd = 0;
    for (int c = 0; c < 8; c++) begin
      step(c == 0, 3, 0, 0, 0, 0, 0, 0);
      if (a_done) nd++;
      n_vec++;
      if (got_a() !== expv(ma_t, ma_idx, ma_en, ma_h, 4) || a_y !== 4'b0) begin
        n_err++;
        $display("FAIL disabled c=%0d got=%b exp=%b", c + 1, got_a(),
                 expv(ma_t, ma_idx, ma_en, ma_h, 4));
      end
    end
    n_vec++;
    if (nd != 1 || a_hist !== 4'b1011) begin
      n_err++;
      $display("FAIL disabled_sum got done=%0d hist=%b exp 1 and 1011",
               nd, a_hist);
    end
  endtask

  task automatic test_clear_collision();
    step(0, 0, 0, 1, 0, 0, 0, 0);
    for (int c = 0; c < 12; c++) begin
      step(c == 0 || c == 6, (c == 0) ? 0 : 1, 1, 0, 0, 0, 0, 0);
      n_vec++;
      if (got_a() !== expv(ma_t, ma_idx, ma_en, ma_h, 4)) begin
        n_err++;
        $display("FAIL clr_setup c=%0d got=%b exp=%b", c, got_a(),
                 expv(ma_t, ma_idx, ma_en, ma_h, 4));
      end
    end
    n_vec++;
    if (a_hist !== 4'b0011) begin
      n_err++;
      $display("FAIL clr_pre got=%b exp=0011", a_hist);
    end
    step(1, 2, 1, 1, 0, 0, 0, 0);
    n_vec++;
    if (a_hist !== 4'b0100) begin
      n_err++;
      $display("FAIL clr_collision got=%b exp=0100", a_hist);
    end
    for (int c = 0; c < 6; c++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random_a();
    for (int c = 0; c < 300; c++) begin
      step($urandom_range(1, 0) == 1, int'($urandom_range(3, 0)),
           $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0,
           0, 0, 0, 0);
      n_vec++;
      if (got_a() !== expv(ma_t, ma_idx, ma_en, ma_h, 4)) begin
        n_err++;
        $display("FAIL rand_a c=%0d got=%b exp=%b", c, got_a(),
                 expv(ma_t, ma_idx, ma_en, ma_h, 4));
      end
    end
    for (int c = 0; c < 6; c++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_edge_b();
    int dc[$];
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 0, c < 3, (c == 0) ? 1 : 2, 1, 0);
      if (b_done) dc.push_back(c);
      n_vec++;
      if (got_b() !== expv(mb_t, mb_idx, mb_en, mb_h, 1)) begin
        n_err++;
        $display("FAIL edge_b c=%0d got=%b exp=%b", c, got_b(),
                 expv(mb_t, mb_idx, mb_en, mb_h, 1));
      end
    end
    n_vec++;
    if (dc.size() < 2 || dc[0] != 0 || dc[1] != 2) begin
      n_err++;
      $display("FAIL edge_b_reaccept got %0d pulses exp at cycles 0 and 2",
               dc.size());
    end
    for (int c = 0; c < 200; c++) begin
      step(0, 0, 0, 0, $urandom_range(1, 0) == 1,
           int'($urandom_range(3, 0)), $urandom_range(3, 0) != 0,
           $urandom_range(7, 0) == 0);
      n_vec++;
      if (got_b() !== expv(mb_t, mb_idx, mb_en, mb_h, 1)) begin
        n_err++;
        $display("FAIL rand_b c=%0d got=%b exp=%b", c, got_b(),
                 expv(mb_t, mb_idx, mb_en, mb_h, 1));
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_abort();
    int nd = 0;
    step(1, 1, 1, 0, 1, 3, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (a_y !== 4'b0010 || b_busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pre got a_y=%b b_busy=%b exp 0010 0", a_y, b_busy);
    end
    step(0, 0, 0, 0, 1, 3, 1, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({a_y, a_busy, a_done, b_y, b_busy, b_done} !== 12'b0) begin
      n_err++;
      $display("FAIL abort_kill got a=%b b=%b exp all idle", got_a(), got_b());
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      if (a_done || b_done) nd++;
      n_vec++;
      if ({got_a(), got_b()} !== {expv(ma_t, ma_idx, ma_en, ma_h, 4),
                                  expv(mb_t, mb_idx, mb_en, mb_h, 1)}) begin
        n_err++;
        $display("FAIL abort_after c=%0d got a=%b b=%b", c, got_a(), got_b());
      end
    end
    n_vec++;
    if (nd != 0) begin
      n_err++;
      $display("FAIL abort_done got=%0d exp=0", nd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_disabled();
    test_clear_collision();
    test_random_a();
    test_edge_b();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/onehot_dec_seq.md
# onehot_dec_seq

Sequenced 2-to-4 one-hot decoder: the companion to the team's 4-to-2 priority encoder, turning an accepted 2-bit index back into a one-hot line. It accepts an index through a valid/ready handshake and drives the matching output line for a fixed window of HOLD cycles, then a guard gap of GAP cycles. It also keeps a sticky history of which lines have fired. It sits downstream of the encoder, which sources `in_idx`/`in_en`, and drives per-line strobes in the ALU lab datapath.

## Interface
- HOLD, 4: cycles each one-hot output stays asserted; legal 1..15.
- GAP, 1: idle cycles after each HOLD window, before the next accept; legal 0..15.

- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept; high only in IDLE.
- in_idx  input  2  line index to decode (0..3).
- in_en  input  1  decode enable, sampled with `in_idx`; 0 = consume request but keep `y` all-zero.
- clr  input  1  synchronous clear of `hist`.
- y  output  4  registered one-hot output; `y[in_idx]` during HOLD.
- busy  output  1  high in HOLD or GAP.
- done  output  1  high during the final HOLD cycle of each request.
- hist  output  4  sticky OR of every line driven since reset or `clr`.

## Operation
- Accept: `in_valid & in_ready` at a rising edge. The block captures `in_idx` and `in_en`, loads `cnt = HOLD-1`, and enters HOLD. `in_idx`/`in_en` are ignored at all other times.
- States (2-bit state register, 4-bit `cnt`):
  - IDLE: `in_ready=1`, `y=0`, `busy=0`. On accept -> HOLD.
  - HOLD: `y = in_en ? (4'b0001 << idx) : 4'b0000`; `busy=1`. If `cnt!=0`, decrement `cnt`. If `cnt==0`: when GAP>0, go to GAP with `cnt=GAP-1`; when GAP==0, go to IDLE.
  - GAP: `y=0`, `busy=1`, `in_ready=0`. If `cnt!=0`, decrement `cnt`; if `cnt==0`, go to IDLE.
- `done`:
  - `done = (state==HOLD) & (cnt==0)`, exactly one cycle per accepted request.
  - It pulses even when `in_en=0`.
- `hist`:
  - On accept with `in_en=1`, bit `in_idx` is set.
  - Next value is `(clr ? 4'b0 : hist) | newbit`. When `clr` and an accept happen on the same edge, the new bit survives and all others clear.
- `y` is never multi-hot; it is all-zero outside HOLD and whenever the captured `in_en=0`.
- Parameters outside their legal ranges must fail elaboration.

## Timing
- Reset (asynchronous, any time) sets:
  - state=IDLE, `cnt=0`, `y=0`, `busy=0`, `done=0`, `hist=0`, `in_ready=1`.
  - An in-flight request is aborted with no `done`.
- Latency:
  - Accept at edge E0 -> `y` valid in cycles 1..HOLD after E0.
  - `done` is high in cycle HOLD.
  - GAP occupies cycles HOLD+1..HOLD+GAP.
  - `in_ready` rises in cycle HOLD+GAP+1.
- Throughput: one request per HOLD+GAP+1 cycles. With GAP=0 there is still one IDLE cycle between windows.
- `in_ready` depends only on registered state, with no combinational path from `in_valid`. `y`, `busy`, `done` and `hist` are registered or decoded from registered state only.
- `in_valid` may stay high across busy cycles. The held request is accepted on the first IDLE edge.

## Test plan
- Reset check: assert `rst` mid-cycle, then release. Required: `y=0`, `hist=0`, `in_ready=1`, `busy=0` immediately and after release.
- Default params (HOLD=4, GAP=1): accept `in_idx=2`, `in_en=1` at E0. Required:
  - `y=4'b0100` in cycles 1-4; `done` only in cycle 4.
  - `y=0` with `busy=1` in cycle 5; `in_ready=1` in cycle 6.
  - `hist=4'b0100`.
- Back-to-back: hold `in_valid=1` with `in_idx` stepping 0,1,3. Required:
  - Accepts exactly every 6 cycles.
  - `y` sequence 0001, 0010, 1000.
  - `hist=4'b1011`; three `done` pulses.
- Disabled request: accept `in_idx=3`, `in_en=0`. Required: `y` stays 0 for the whole window, `done` still pulses in cycle 4, `hist` unchanged.
- Clear collision: `hist=4'b0011`, then `clr=1` on the same edge as an accept of `in_idx=2`. Required: `hist=4'b0100`.
- Edge params (HOLD=1, GAP=0) plus reset abort:
  - One-cycle `y` with `done` coincident; re-accept two cycles later.
  - Separately, asserting `rst` during HOLD kills `y` at once and no `done` follows.
